// File: rtl/mask_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : mask_encoder_seq
// Brief    : Walks a 2^N-bit multi-hot mask and emits the index of each set
//            bit, one per output handshake. Define MASK_ENC_MSB_FIRST_EN to
//            emit the highest set bit first instead of the lowest.
// Revision : 1.0 - initial release
// ============================================================================
module mask_encoder_seq #(
    parameter int N = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [(1 << N)-1:0]   in_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_idx,
    output logic                  out_last,
    output logic                  busy
);

    localparam int                  c_width   = 1 << N;
    localparam logic [c_width-1:0]  c_one     = c_width'(1);
    localparam logic [0:0]          c_st_idle = 1'b0;
    localparam logic [0:0]          c_st_scan = 1'b1;

    logic [0:0]          r_state;
    logic [c_width-1:0]  r_rem;
    logic [N-1:0]        w_idx;
    logic                w_last;
    logic [c_width-1:0]  w_clear;

    // The last match in the loop wins, so loop direction sets scan order.
    always_comb begin
        w_idx = '0;
`ifdef MASK_ENC_MSB_FIRST_EN
        for (int i = 0; i < c_width; i++) begin
            if (r_rem[i]) w_idx = N'(i);
        end
`else
        for (int i = c_width - 1; i >= 0; i--) begin
            if (r_rem[i]) w_idx = N'(i);
        end
`endif
    end

    always_comb begin
        w_clear        = '0;
        w_clear[w_idx] = 1'b1;
    end

    // Exactly one bit remaining: non-zero and clearing the lowest bit empties it.
    assign w_last = (r_rem != '0) && ((r_rem & (r_rem - c_one)) == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_rem   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    // An all-zero mask is consumed without leaving IDLE.
                    if (in_valid && (in_mask != '0)) begin
                        r_rem   <= in_mask;
                        r_state <= c_st_scan;
                    end
                end
                c_st_scan: begin
                    if (out_ready) begin
                        r_rem <= r_rem & ~w_clear;
                        if (w_last) r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_rem   <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_scan);
    assign busy      = (r_state == c_st_scan);
    assign out_idx   = w_idx;
    assign out_last  = w_last;

endmodule
`default_nettype wire

// File: tb/tb_mask_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mask_encoder_seq
// Brief    : Self-checking bench for mask_encoder_seq (N=3) using a queue
//            based reference of the expected index sequence per mask.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mask_encoder_seq;

    localparam int N = 3;
    localparam int W = 1 << N;

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_mask;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_idx;
    logic          out_last;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef int iq_t[$];

    mask_encoder_seq #(.N(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected emission order: set-bit positions sorted by the selected order.
    function automatic iq_t model(input logic [W-1:0] m);
        iq_t q;
        for (int i = 0; i < W; i++) begin
            if (m[i]) begin
`ifdef MASK_ENC_MSB_FIRST_EN
                q.push_front(i);
`else
                q.push_back(i);
`endif
            end
        end
        return q;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_out_idx"},   out_idx,   0);
        chk({tag, "_out_last"},  out_last,  0);
    endtask

    // Called at a negedge while idle; returns at the negedge after acceptance.
    task automatic send(input logic [W-1:0] m);
        chk("send_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_mask  = m;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // mode 1: out_ready always 1; mode 2: out_ready from pat bits; else random.
    task automatic drain(input logic [W-1:0] m, input int max_beats,
                         input int mode, input logic [31:0] pat);
        iq_t  q;
        int   cyc;
        int   beats;
        logic r;
        q     = model(m);
        cyc   = 0;
        beats = 0;
        while (q.size() > 0 && beats < max_beats && cyc < 64) begin
            chk("out_valid", out_valid, 1);
            chk("out_idx",   out_idx,   q[0]);
            chk("out_last",  out_last,  (q.size() == 1));
            chk("busy",      busy,      1);
            chk("in_ready",  in_ready,  0);
            if (mode == 1)      r = 1'b1;
            else if (mode == 2) r = pat[cyc % 32];
            else                r = (cyc >= 32) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = r;
            @(negedge clock);
            cyc++;
            if (r) begin
                void'(q.pop_front());
                beats++;
            end
        end
        out_ready = 1'b0;
        if (cyc >= 64) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        out_ready = 1'b0;
        #1;
        check_idle("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_idle("post_reset");

        // Sparse mask, full-throughput drain.
        send(8'b1010_0101);
        drain(8'b1010_0101, 99, 1, 0);
        check_idle("after_a5");

        // Backpressure: ready pattern 1,0,0,1.
        send(8'b0001_0010);
        drain(8'b0001_0010, 99, 2, 32'b1001);
        check_idle("after_12");

        // Zero mask is consumed silently.
        send(8'h00);
        check_idle("zero_mask");
        @(negedge clock);
        check_idle("zero_mask_hold");

        // Reset in the middle of an all-ones scan.
        send(8'hFF);
        drain(8'hFF, 4, 1, 0);
        reset_n = 1'b0;
        #1;
        check_idle("mid_reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        send(8'h40);
        drain(8'h40, 99, 1, 0);
        check_idle("after_40");

        // Back-to-back with in_valid held high.
        in_valid = 1'b1;
        in_mask  = 8'h80;
        @(negedge clock);
        in_mask   = 8'h01;
        out_ready = 1'b1;
        chk("b2b_first_valid", out_valid, 1);
        chk("b2b_first_idx",   out_idx,   7);
        chk("b2b_first_last",  out_last,  1);
        chk("b2b_first_ready", in_ready,  0);
        @(negedge clock);
        chk("b2b_gap_ready", in_ready,  1);
        chk("b2b_gap_valid", out_valid, 0);
        @(negedge clock);
        in_valid = 1'b0;
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second_idx",   out_idx,   0);
        chk("b2b_second_last",  out_last,  1);
        @(negedge clock);
        out_ready = 1'b0;
        check_idle("after_b2b");

        // Full all-ones drain.
        send(8'hFF);
        drain(8'hFF, 99, 1, 0);
        check_idle("after_ff");

        // Randomised masks and backpressure.
        for (int t = 0; t < 30; t++) begin
            logic [W-1:0] m;
            m = W'($urandom);
            send(m);
            drain(m, 99, 0, 0);
            check_idle("rand_idle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
